div_seq: RTL and testbench

Multi-cycle sequencer and datapath for the MIPS DIV/DIVU instructions in the EX stage. The upstream decoder raises `start` and `signed_div` when the ALU control selects the DIV or DIVU operation. The block runs a 32-step restoring shift-subtract division and asserts `stall_req` to hold the pipeline until it finishes. It then presents {remainder, quotient} for the HI/LO write.

---
 rtl/div_seq_if.sv | 23 ++
 rtl/div_seq.sv | 131 +++++++++++++
 tb/tb_div_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Request/result bundle between the EX-stage control and the DIV/DIVU sequencer.
interface div_seq_if;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  // Pipeline side: issues the request and consumes the result.
  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, stall_req
  );

  // Divider side.
  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, stall_req
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU unit: 32-step restoring shift-subtract on magnitudes,
// with sign fix-up applied once on the final step. Holds the pipeline with
// stall_req until {remainder, quotient} is presented with ready.
module div_seq (
  input  logic      clk,
  input  logic      resetn,
  div_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [4:0]  cnt_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        ready_q;
  logic [63:0] result_q;

  logic [32:0] part;
  logic [32:0] diff;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] fix_rem;
  logic [31:0] fix_quo;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  // Operand magnitudes at acceptance; the most negative value wraps to itself,
  // which is exactly what the unsigned core needs for 0x80000000.
  always_comb begin
    abs_a = (bus.signed_div && bus.opdata1[31]) ? 32'd0 - bus.opdata1 : bus.opdata1;
    abs_b = (bus.signed_div && bus.opdata2[31]) ? 32'd0 - bus.opdata2 : bus.opdata2;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    part = {rem_q, quo_q[31]};
    diff = part - {1'b0, dvs_q};
    if (!diff[32]) begin
      rem_d = diff[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end else begin
      rem_d = part[31:0];
      quo_d = {quo_q[30:0], 1'b0};
    end
    fix_rem = neg_rem_q ? 32'd0 - rem_d : rem_d;
    fix_quo = neg_quo_q ? 32'd0 - quo_d : quo_d;
  end

  // Sequencer and datapath registers, including the registered result/ready outputs.
  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.annul) begin
            if (bus.opdata2 == 32'd0) begin
              state_q <= S_BYZERO;
            end else begin
              state_q   <= S_BUSY;
              quo_q     <= abs_a;
              rem_q     <= '0;
              dvs_q     <= abs_b;
              cnt_q     <= '0;
              neg_quo_q <= bus.signed_div & (bus.opdata1[31] ^ bus.opdata2[31]);
              neg_rem_q <= bus.signed_div & bus.opdata1[31];
            end
          end
        end
        S_BYZERO: begin
          if (bus.annul) begin
            state_q <= S_IDLE;
          end else begin
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_BUSY: begin
          if (bus.annul) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q  <= S_DONE;
              ready_q  <= 1'b1;
              result_q <= {fix_rem, fix_quo};
            end
          end
        end
        S_DONE: begin
          if (bus.annul || !bus.start) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.ready     = ready_q;
  // Stall is combinational so it covers the acceptance cycle; gated off during reset.
  assign bus.stall_req = resetn & bus.start & ~bus.annul & (state_q != S_DONE);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vectors with literal expectations,
// plus a cycle-level reference model compared every cycle.
module tb_div_seq;

  logic clk;
  logic resetn;
  div_seq_if bus ();

  div_seq dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic from the instruction's definition: truncating division,
  // remainder takes the dividend's sign, divide-by-zero yields 0.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  // Cycle-level model: counts edges from acceptance to completion.
  logic        m_active = 1'b0;
  logic        m_ready  = 1'b0;
  int          m_left   = 0;
  logic [63:0] m_res    = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_active = 1'b0;
      m_ready  = 1'b0;
      m_left   = 0;
    end else if (m_ready) begin
      if (bus.annul || !bus.start) m_ready = 1'b0;
    end else if (m_active) begin
      if (bus.annul) begin
        m_active = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_active = 1'b0;
          m_ready  = 1'b1;
        end
      end
    end else if (bus.start && !bus.annul) begin
      m_active = 1'b1;
      m_left   = (bus.opdata2 == 32'd0) ? 1 : 32;
      m_res    = ref_div(bus.signed_div, bus.opdata1, bus.opdata2);
    end
  end

  // Compare outputs against the model away from the active edge.
  always @(negedge clk) begin
    check("ready", {63'd0, bus.ready}, {63'd0, m_ready});
    check("result", bus.result, m_ready ? m_res : 64'd0);
    check("stall_req", {63'd0, bus.stall_req},
          {63'd0, resetn & bus.start & ~bus.annul & ~m_ready});
  end

  task automatic run_op(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int cycles;
    int lat;
    check({name, " model"}, ref_div(s, a, b), exp);
    lat = (b == 32'd0) ? 2 : 33;
    bus.signed_div = s;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    cycles = 0;
    while (!bus.ready && cycles < 60) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) begin
        // Operands are irrelevant once accepted.
        bus.opdata1    = $urandom;
        bus.opdata2    = $urandom;
        bus.signed_div = ~s;
      end
    end
    check({name, " latency"}, 64'(cycles), 64'(lat));
    check({name, " result"}, bus.result, exp);
    @(posedge clk); #1;
    check({name, " held"}, bus.result, exp);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check({name, " ready drop"}, {63'd0, bus.ready}, 64'd0);
  endtask

  initial begin
    resetn         = 1'b0;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.annul      = 1'b0;

    #12;
    check("reset ready", {63'd0, bus.ready}, 64'd0);
    check("reset result", bus.result, 64'd0);
    bus.start = 1'b1;
    #1;
    check("reset stall forced", {63'd0, bus.stall_req}, 64'd0);
    bus.start = 1'b0;
    #4 resetn = 1'b1;
    @(posedge clk); #1;

    run_op("divu 7/2",      1'b0, 32'd7,        32'd2,        64'h00000001_00000003);
    run_op("div -7/2",      1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD);
    run_op("div 7/-2",      1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run_op("div ovf",       1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op("divu max/1",    1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF);
    run_op("div by zero",   1'b0, 32'h00001234, 32'd0,        64'd0);
    run_op("divu max/max",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    run_op("div -100/-7",   1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E);

    // Request with annul in IDLE is rejected.
    bus.start = 1'b1; bus.annul = 1'b1; bus.opdata1 = 32'd5; bus.opdata2 = 32'd1;
    #1;
    check("reject stall", {63'd0, bus.stall_req}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reject ready", {63'd0, bus.ready}, 64'd0);
    bus.start = 1'b0; bus.annul = 1'b0;
    @(posedge clk); #1;

    // Annul ten cycles into BUSY.
    bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3; bus.start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    #1;
    check("annul stall", {63'd0, bus.stall_req}, 64'd0);
    @(posedge clk); #1;
    bus.annul = 1'b0; bus.start = 1'b0;
    check("annul ready", {63'd0, bus.ready}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("annul no late ready", {63'd0, bus.ready}, 64'd0);
    run_op("divu 100/7",    1'b0, 32'd100,      32'd7,        64'h00000002_0000000E);

    // Reset in the middle of BUSY.
    bus.signed_div = 1'b0; bus.opdata1 = 32'd77; bus.opdata2 = 32'd5; bus.start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("midreset ready", {63'd0, bus.ready}, 64'd0);
    check("midreset result", bus.result, 64'd0);
    check("midreset stall", {63'd0, bus.stall_req}, 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    run_op("divu 9/3",      1'b0, 32'd9,        32'd3,        64'h00000000_00000003);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
